// File: rtl/ram_rr_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_rr_arbiter.
// slave = arbiter side, master = requesters plus RAM side.
interface ram_rr_arbiter_if #(
  parameter int DATA_W  = 32,
  parameter int MEM_LEN = 32
);
  localparam int ADDR_W = $clog2(MEM_LEN);

  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [DATA_W-1:0]   ram_wdata;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_address;
  logic [DATA_W-1:0]   ram_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, ram_wdata, ram_we, ram_address
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, ram_wdata, ram_we, ram_address
  );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with registered read data.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module ram_rr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int MEM_LEN = 32
) (
  input logic               clk,
  input logic               rst,
  ram_rr_arbiter_if.slave   bus
);
  localparam int ADDR_W = $clog2(MEM_LEN);

  logic              gnt_vld;
  logic              gnt_idx;
  logic              gnt_write;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic              prio;

  logic              ram_we_d,      ram_we_q;
  logic [ADDR_W-1:0] ram_address_d, ram_address_q;
  logic [DATA_W-1:0] ram_wdata_d,   ram_wdata_q;
  logic              vld_p0_d, vld_p0_q, gnt_p0_d, gnt_p0_q;
  logic              vld_p1_d, vld_p1_q, gnt_p1_d, gnt_p1_q;
  logic              vld_p2_d, vld_p2_q, gnt_p2_d, gnt_p2_q;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign prio = 1'b0;
`else
  logic prio_d, prio_q;

  always_comb begin
    prio_d = prio_q;
    if (gnt_vld) prio_d = ~gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  assign prio = prio_q;
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 1'b0;
    if (!rst) begin
      unique case (bus.req_valid)
        2'b01:   begin gnt_vld = 1'b1; gnt_idx = 1'b0; end
        2'b10:   begin gnt_vld = 1'b1; gnt_idx = 1'b1; end
        2'b11:   begin gnt_vld = 1'b1; gnt_idx = prio; end
        default: begin gnt_vld = 1'b0; gnt_idx = 1'b0; end
      endcase
    end
  end

  assign gnt_write = gnt_idx ? bus.req_write[1] : bus.req_write[0];
  assign gnt_addr  = gnt_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
  assign gnt_wdata = gnt_idx ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];

  assign bus.req_ready = gnt_vld ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

  // Issue stage: idle cycles hold address/data and keep the RAM in read mode.
  always_comb begin
    ram_we_d      = 1'b1;
    ram_address_d = ram_address_q;
    ram_wdata_d   = ram_wdata_q;
    if (gnt_vld) begin
      ram_we_d      = ~gnt_write;
      ram_address_d = gnt_addr;
      ram_wdata_d   = gnt_wdata;
    end
    vld_p0_d = gnt_vld & ~gnt_write;
    gnt_p0_d = gnt_idx;
  end

  // RAM access stage, then response stage aligned with ram_rdata.
  always_comb begin
    vld_p1_d = vld_p0_q;
    gnt_p1_d = gnt_p0_q;
    vld_p2_d = vld_p1_q;
    gnt_p2_d = gnt_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we_q      <= 1'b1;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
      vld_p0_q      <= 1'b0;
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
    end else begin
      ram_we_q      <= ram_we_d;
      ram_address_q <= ram_address_d;
      ram_wdata_q   <= ram_wdata_d;
      vld_p0_q      <= vld_p0_d;
      vld_p1_q      <= vld_p1_d;
      vld_p2_q      <= vld_p2_d;
    end
    gnt_p0_q <= gnt_p0_d;
    gnt_p1_q <= gnt_p1_d;
    gnt_p2_q <= gnt_p2_d;
  end

  assign bus.ram_we      = ram_we_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.rsp_valid   = vld_p2_q ? (gnt_p2_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata   = bus.ram_rdata;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural RAM and a read-response scoreboard.
// RAM model: port sampled at the access edge, read data registered once more before it reaches rdata.
module tb_ram_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_rr_arbiter_if #(.DATA_W(32), .MEM_LEN(32)) bus ();

  ram_rr_arbiter #(.DATA_W(32), .MEM_LEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [31:0] ram_mem [32];
  logic [31:0] ram_rd_stage;
  always @(posedge clk) begin
    if (bus.ram_we === 1'b0) ram_mem[bus.ram_address] <= bus.ram_wdata;
    ram_rd_stage  <= ram_mem[bus.ram_address];
    bus.ram_rdata <= ram_rd_stage;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int rsp_cnt  = 0;
  logic [31:0] mdl [32];
  logic [32:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every read pulse must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (bus.rsp_valid !== 2'b00) begin
      logic [32:0] e;
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("rsp_unexpected", {62'd0, bus.rsp_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_who", {62'd0, bus.rsp_valid}, e[32] ? 64'd2 : 64'd1);
        check("rsp_data", {32'd0, bus.rsp_rdata}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic cyc(input logic r, input logic [1:0] v, input logic [1:0] w,
                     input logic [4:0] a0, input logic [4:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] exp_rdy);
    rst           = r;
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    @(negedge clk);
    check("req_ready", {62'd0, bus.req_ready}, {62'd0, exp_rdy});
    if (r) sb.delete();
    for (int i = 0; i < 2; i++) begin
      if (exp_rdy[i]) begin
        logic [4:0] a;
        a = (i == 1) ? a1 : a0;
        if (w[i]) mdl[a] = (i == 1) ? d1 : d0;
        else      sb.push_back({(i == 1), mdl[a]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
  endtask

  initial begin
    logic [1:0] g;
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_write = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    @(posedge clk);
    #1;

    // Reset held with both requesters asking to write
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 2'b11, 2'b11, 5'd1, 5'd2, 32'h1111_0001, 32'h2222_0002, 2'b00);
      check("rst_ram_we", {63'd0, bus.ram_we}, 64'd1);
      check("rst_rsp_valid", {62'd0, bus.rsp_valid}, 64'd0);
    end

    // First grant after reset goes to requester 0
    cyc(1'b0, 2'b11, 2'b11, 5'd1, 5'd2, 32'h1111_0001, 32'h2222_0002, 2'b01);
    check("first_we", {63'd0, bus.ram_we}, 64'd0);
    check("first_addr", {59'd0, bus.ram_address}, 64'd1);
    cyc(1'b0, 2'b10, 2'b10, 5'd1, 5'd2, 32'h1111_0001, 32'h2222_0002, 2'b10);

    // Continuous contention on reads
    for (int k = 0; k < 6; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      g = 2'b01;
`else
      g = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      cyc(1'b0, 2'b11, 2'b00, 5'd1, 5'd2, 32'd0, 32'd0, g);
    end
    repeat (4) idle();
    check("contention_rsp_cnt", 64'(rsp_cnt), 64'd6);

    // Requester 1 alone: write then read, check exact latency
    cyc(1'b0, 2'b10, 2'b10, 5'd0, 5'd5, 32'd0, 32'hDEAD_BEEF, 2'b10);
    cyc(1'b0, 2'b10, 2'b00, 5'd0, 5'd5, 32'd0, 32'd0, 2'b10);
    check("lat_n0", {62'd0, bus.rsp_valid}, 64'd0);
    idle();
    check("lat_n1", {62'd0, bus.rsp_valid}, 64'd0);
    idle();
    check("lat_n2_valid", {62'd0, bus.rsp_valid}, 64'd2);
    check("lat_n2_data", {32'd0, bus.rsp_rdata}, 64'hDEAD_BEEF);
    repeat (2) idle();

    // Cross-requester read-after-write
    cyc(1'b0, 2'b01, 2'b01, 5'd3, 5'd0, 32'h1234_5678, 32'd0, 2'b01);
    cyc(1'b0, 2'b10, 2'b00, 5'd0, 5'd3, 32'd0, 32'd0, 2'b10);
    repeat (4) idle();

    // Idle safety: no spurious write while nothing is requested
    cyc(1'b0, 2'b01, 2'b01, 5'd0, 5'd0, 32'hA5A5_A5A5, 32'd0, 2'b01);
    for (int k = 0; k < 10; k++) begin
      idle();
      check("idle_ram_we", {63'd0, bus.ram_we}, 64'd1);
    end
    cyc(1'b0, 2'b01, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b01);
    repeat (4) idle();

    // Reset one cycle after a read is accepted: the response is dropped
    cyc(1'b0, 2'b01, 2'b00, 5'd1, 5'd0, 32'd0, 32'd0, 2'b01);
    cyc(1'b1, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
    check("midrst_ram_we", {63'd0, bus.ram_we}, 64'd1);
    repeat (5) idle();
    cyc(1'b0, 2'b11, 2'b00, 5'd2, 5'd1, 32'd0, 32'd0, 2'b01);
    repeat (4) idle();

    check("sb_drained", 64'(sb.size()), 64'd0);
    check("total_rsp_cnt", 64'(rsp_cnt), 64'd10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
